// File: rtl/sar_comparator_responder.sv
// Comparator, sample/hold and conversion sequencer for the SAR ADC loop.
// Answers SAR trial codes with a registered, offset- and noise-affected decision.
module sar_comparator_responder #(
    parameter int          N_BITS     = 10,
    parameter int          OFFSET     = 0,
    parameter int          NOISE_BITS = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [N_BITS-1:0] sample_code,
    output logic              conduct_comparison,
    input  logic [N_BITS-1:0] trial_code,
    input  logic              sar_eoc,
    output logic              feedback_value,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [N_BITS-1:0] result_code,
    output logic              result_error
);
    // state     | meaning
    // S_IDLE    | waiting for a sample, sample_ready high
    // S_CONVERT | 2*N_BITS cycles of SAR stepping, two phases per bit
    // S_DONE    | result presented until the consumer takes it

    localparam int W    = N_BITS + 2;
    localparam int PH_W = $clog2(2 * N_BITS);
    localparam int PHB  = PH_W - 1;
    localparam logic [PH_W-1:0]    PH_LAST  = PH_W'(2 * N_BITS - 1);
    localparam logic [PHB-1:0]     BIT_LAST = PHB'(N_BITS - 1);
    localparam logic signed [W-1:0] OFF_W   = W'(OFFSET);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

    state_t                state;
    logic [PH_W-1:0]       phase;
    logic [N_BITS-1:0]     hold;
    logic                  err_flag;
    logic [15:0]           lfsr;
    logic                  lfsr_fb;
    logic signed [W-1:0]   noise;
    logic signed [W-1:0]   lhs;
    logic signed [W-1:0]   rhs;
    logic                  cmp;
    logic                  eoc_bad;

    if (NOISE_BITS == 0) begin : g_quiet
        assign noise = '0;
    end else begin : g_noisy
        assign noise = W'($signed(lfsr[NOISE_BITS-1:0]));
    end

    // x^16 + x^14 + x^13 + x^11 + 1
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign lhs = $signed({2'b00, hold}) + OFF_W + noise;
    assign rhs = $signed({2'b00, trial_code});
    assign cmp = (lhs >= rhs);

    // SAR should raise eoc for both phases of the last bit only.
    assign eoc_bad = (state == S_CONVERT) && (sar_eoc != (phase[PH_W-1:1] == BIT_LAST));

    assign conduct_comparison = (state == S_CONVERT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            phase          <= '0;
            hold           <= '0;
            err_flag       <= 1'b0;
            lfsr           <= LFSR_SEED;
            feedback_value <= 1'b0;
            sample_ready   <= 1'b1;
            result_valid   <= 1'b0;
            result_code    <= '0;
            result_error   <= 1'b0;
        end else begin
            lfsr           <= {lfsr[14:0], lfsr_fb};
            feedback_value <= cmp;
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        hold         <= sample_code;
                        err_flag     <= 1'b0;
                        phase        <= '0;
                        sample_ready <= 1'b0;
                        state        <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    phase <= phase + 1'b1;
                    if (eoc_bad) begin
                        err_flag <= 1'b1;
                    end
                    if (phase == PH_LAST) begin
                        // LSB is taken from this cycle's comparison, not the registered one.
                        phase        <= '0;
                        result_code  <= {trial_code[N_BITS-1:1], cmp};
                        result_error <= err_flag | eoc_bad;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        sample_ready <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
